// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer operations plus iterative multiply and
// restoring divide writing the HI/LO pair, one bit per cycle.
module alu_seq #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [SIZEOP-1:0]   i_opcode,
    input  logic [SIZEDATA-1:0] i_datoa,
    input  logic [SIZEDATA-1:0] i_datob,
    output logic                o_ready,
    output logic                o_valid,
    output logic [SIZEDATA-1:0] o_result,
    output logic                o_zero
);

    localparam int W  = SIZEDATA;
    localparam int CW = $clog2(W);

    localparam logic [SIZEOP-1:0] OP_SLL   = SIZEOP'(6'b000000);
    localparam logic [SIZEOP-1:0] OP_SRL   = SIZEOP'(6'b000010);
    localparam logic [SIZEOP-1:0] OP_SRA   = SIZEOP'(6'b000011);
    localparam logic [SIZEOP-1:0] OP_SLLV  = SIZEOP'(6'b000100);
    localparam logic [SIZEOP-1:0] OP_SRLV  = SIZEOP'(6'b000110);
    localparam logic [SIZEOP-1:0] OP_SRAV  = SIZEOP'(6'b000111);
    localparam logic [SIZEOP-1:0] OP_ADDU  = SIZEOP'(6'b100001);
    localparam logic [SIZEOP-1:0] OP_SUBU  = SIZEOP'(6'b100011);
    localparam logic [SIZEOP-1:0] OP_AND   = SIZEOP'(6'b100100);
    localparam logic [SIZEOP-1:0] OP_OR    = SIZEOP'(6'b100101);
    localparam logic [SIZEOP-1:0] OP_XOR   = SIZEOP'(6'b100110);
    localparam logic [SIZEOP-1:0] OP_NOR   = SIZEOP'(6'b100111);
    localparam logic [SIZEOP-1:0] OP_SLT   = SIZEOP'(6'b101010);
    localparam logic [SIZEOP-1:0] OP_ADDI  = SIZEOP'(6'b001000);
    localparam logic [SIZEOP-1:0] OP_ANDI  = SIZEOP'(6'b001100);
    localparam logic [SIZEOP-1:0] OP_ORI   = SIZEOP'(6'b001101);
    localparam logic [SIZEOP-1:0] OP_XORI  = SIZEOP'(6'b001110);
    localparam logic [SIZEOP-1:0] OP_LUI   = SIZEOP'(6'b001111);
    localparam logic [SIZEOP-1:0] OP_SLTI  = SIZEOP'(6'b001010);
    localparam logic [SIZEOP-1:0] OP_MFHI  = SIZEOP'(6'b010000);
    localparam logic [SIZEOP-1:0] OP_MFLO  = SIZEOP'(6'b010010);
    localparam logic [SIZEOP-1:0] OP_MULT  = SIZEOP'(6'b011000);
    localparam logic [SIZEOP-1:0] OP_MULTU = SIZEOP'(6'b011001);
    localparam logic [SIZEOP-1:0] OP_DIV   = SIZEOP'(6'b011010);
    localparam logic [SIZEOP-1:0] OP_DIVU  = SIZEOP'(6'b011011);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [W-1:0]    hi_reg, lo_reg;
    logic [W-1:0]    alu_res;
    logic [CW-1:0]   shamt;
    logic            accept, is_mul, is_div, signed_op, last;
    logic            a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;

    logic [2*W-1:0]  acc, mcand, acc_next, prod;
    logic [W-1:0]    mplier;
    logic [W-1:0]    rem, quo, divisor, rem_next, quo_next, q_fin, r_fin;
    logic [W:0]      rem_shift, trial;
    logic            neg_q, neg_r, div_zero;
    logic [W-1:0]    dividend;

    assign accept    = i_valid && o_ready;
    assign is_mul    = (i_opcode == OP_MULT) || (i_opcode == OP_MULTU);
    assign is_div    = (i_opcode == OP_DIV)  || (i_opcode == OP_DIVU);
    assign signed_op = (i_opcode == OP_MULT) || (i_opcode == OP_DIV);
    assign last      = (count == CW'(W - 1));
    assign shamt     = i_datob[CW-1:0];

    // Signed multiply/divide run on magnitudes; signs are fixed up at completion.
    assign a_neg = signed_op && i_datoa[W-1];
    assign b_neg = signed_op && i_datob[W-1];
    assign abs_a = a_neg ? -i_datoa : i_datoa;
    assign abs_b = b_neg ? -i_datob : i_datob;

    always_comb begin
        alu_res = '0;
        case (i_opcode)
            OP_SLL, OP_SLLV:  alu_res = i_datoa << shamt;
            OP_SRL, OP_SRLV:  alu_res = i_datoa >> shamt;
            OP_SRA, OP_SRAV:  alu_res = $signed(i_datoa) >>> shamt;
            OP_ADDU, OP_ADDI: alu_res = i_datoa + i_datob;
            OP_SUBU:          alu_res = i_datoa - i_datob;
            OP_AND, OP_ANDI:  alu_res = i_datoa & i_datob;
            OP_OR, OP_ORI:    alu_res = i_datoa | i_datob;
            OP_XOR, OP_XORI:  alu_res = i_datoa ^ i_datob;
            OP_NOR:           alu_res = ~(i_datoa | i_datob);
            OP_SLT, OP_SLTI:  alu_res = {{(W-1){1'b0}}, ($signed(i_datoa) < $signed(i_datob))};
            OP_LUI:           alu_res = i_datob << (W / 2);
            OP_MFHI:          alu_res = hi_reg;
            OP_MFLO:          alu_res = lo_reg;
            default:          alu_res = '0;
        endcase
    end

    always_comb begin
        acc_next  = acc + (mplier[0] ? mcand : '0);
        prod      = neg_q ? -acc_next : acc_next;
        rem_shift = {rem, quo[W-1]};
        trial     = rem_shift - {1'b0, divisor};
        rem_next  = trial[W] ? rem_shift[W-1:0] : trial[W-1:0];
        quo_next  = {quo[W-2:0], ~trial[W]};
        q_fin     = div_zero ? '1 : (neg_q ? -quo_next : quo_next);
        r_fin     = div_zero ? dividend : (neg_r ? -rem_next : rem_next);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)      state_next = MUL;
                else if (accept && is_div) state_next = DIV;
            end
            MUL, DIV: if (last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
    end

    // Iteration registers are loaded on every acceptance; they only matter while busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count    <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            o_result <= '0;
            o_zero   <= 1'b1;
            o_valid  <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    count    <= '0;
                    acc      <= '0;
                    mcand    <= {{W{1'b0}}, abs_a};
                    mplier   <= abs_b;
                    rem      <= '0;
                    quo      <= abs_a;
                    divisor  <= abs_b;
                    neg_q    <= a_neg ^ b_neg;
                    neg_r    <= a_neg;
                    div_zero <= (i_datob == '0);
                    dividend <= i_datoa;
                    if (!is_mul && !is_div) begin
                        o_result <= alu_res;
                        o_zero   <= (alu_res == '0);
                        o_valid  <= 1'b1;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= last ? '0 : count + 1'b1;
                    if (last) begin
                        hi_reg   <= prod[2*W-1:W];
                        lo_reg   <= prod[W-1:0];
                        o_result <= prod[W-1:0];
                        o_zero   <= (prod[W-1:0] == '0);
                        o_valid  <= 1'b1;
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= last ? '0 : count + 1'b1;
                    if (last) begin
                        hi_reg   <= r_fin;
                        lo_reg   <= q_fin;
                        o_result <= q_fin;
                        o_zero   <= (q_fin == '0);
                        o_valid  <= 1'b1;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at the default 8-bit width.
module tb_alu_seq;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    logic       i_clk, i_rst_n, i_valid;
    logic [5:0] i_opcode;
    logic [7:0] i_datoa, i_datob;
    logic       o_ready, o_valid, o_zero;
    logic [7:0] o_result;

    int checks = 0;
    int passes = 0;

    alu_seq #(.SIZEDATA(8), .SIZEOP(6)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_opcode (i_opcode),
        .i_datoa  (i_datoa),
        .i_datob  (i_datob),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_zero   (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive one request on the next rising edge; outputs are sampled 1 ns after it.
    task automatic applyStimulus(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_opcode = op;
        i_datoa  = a;
        i_datob  = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic runSingle(input string tag, input logic [5:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] exp);
        applyStimulus(op, a, b);
        checkOutput({tag, " result"}, 16'(o_result), 16'(exp));
        checkOutput({tag, " valid"}, 16'(o_valid), 16'd1);
    endtask

    task automatic waitReady(output int cycles, output int early_valid);
        cycles = 0;
        early_valid = 0;
        while (!o_ready && cycles < 64) begin
            @(posedge i_clk);
            #1;
            cycles++;
            if (!o_ready && o_valid) early_valid++;
        end
    endtask

    task automatic runMulti(input string tag, input logic [5:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] exp_lo);
        int cyc, ev;
        applyStimulus(op, a, b);
        checkOutput({tag, " busy"}, 16'(o_ready), 16'd0);
        waitReady(cyc, ev);
        checkOutput({tag, " busy cycles"}, 16'(cyc), 16'd8);
        checkOutput({tag, " early valid"}, 16'(ev), 16'd0);
        checkOutput({tag, " lo"}, 16'(o_result), 16'(exp_lo));
        checkOutput({tag, " valid"}, 16'(o_valid), 16'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, ev, pulses;
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_opcode = '0;
        i_datoa  = '0;
        i_datob  = '0;
        #12;
        checkOutput("reset ready", 16'(o_ready), 16'd1);
        checkOutput("reset valid", 16'(o_valid), 16'd0);
        checkOutput("reset result", 16'(o_result), 16'd0);
        checkOutput("reset zero", 16'(o_zero), 16'd1);

        // First acceptance lands on the very first edge after release.
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        i_valid  = 1'b1;
        i_opcode = OP_ADDU;
        i_datoa  = 8'd100;
        i_datob  = 8'd27;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        checkOutput("addu result", 16'(o_result), 16'd127);
        checkOutput("addu valid", 16'(o_valid), 16'd1);
        checkOutput("addu zero", 16'(o_zero), 16'd0);

        runSingle("subu", OP_SUBU, 8'd5, 8'd5, 8'd0);
        checkOutput("subu zero", 16'(o_zero), 16'd1);
        @(posedge i_clk);
        #1;
        checkOutput("idle valid", 16'(o_valid), 16'd0);
        checkOutput("idle hold", 16'(o_result), 16'd0);

        runSingle("sra", OP_SRA, 8'h80, 8'h0B, 8'hF0);
        runSingle("srl", OP_SRL, 8'h80, 8'h0B, 8'h10);
        runSingle("sll", OP_SLL, 8'h81, 8'h01, 8'h02);
        runSingle("lui", OP_LUI, 8'h00, 8'h12, 8'h20);
        runSingle("slt", OP_SLT, 8'hFF, 8'h01, 8'h01);
        runSingle("slti", OP_SLTI, 8'h01, 8'hFF, 8'h00);
        runSingle("nor", OP_NOR, 8'h0F, 8'h30, 8'hC0);
        runSingle("addi wrap", OP_ADDI, 8'hF0, 8'h20, 8'h10);
        runSingle("unknown", OP_BAD, 8'h12, 8'h34, 8'h00);

        runMulti("mult", OP_MULT, 8'hFD, 8'h05, 8'hF1);
        runSingle("mfhi mult", OP_MFHI, 8'h00, 8'h00, 8'hFF);
        runSingle("mflo mult", OP_MFLO, 8'h00, 8'h00, 8'hF1);
        runMulti("multu", OP_MULTU, 8'hFD, 8'h05, 8'hF1);
        runSingle("mfhi multu", OP_MFHI, 8'h00, 8'h00, 8'h04);

        runMulti("div", OP_DIV, 8'hF9, 8'h02, 8'hFD);
        runSingle("mfhi div", OP_MFHI, 8'h00, 8'h00, 8'hFF);
        runMulti("divu zero", OP_DIVU, 8'h2A, 8'h00, 8'hFF);
        runSingle("mfhi divu zero", OP_MFHI, 8'h00, 8'h00, 8'h2A);
        runMulti("div min", OP_DIV, 8'h80, 8'hFF, 8'h80);
        runSingle("mfhi div min", OP_MFHI, 8'h00, 8'h00, 8'h00);

        // Request held high with new operands while the multiplier is busy.
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_opcode = OP_MULT;
        i_datoa  = 8'd2;
        i_datob  = 8'd3;
        @(posedge i_clk);
        #1;
        i_opcode = OP_ADDU;
        i_datoa  = 8'd1;
        i_datob  = 8'd1;
        waitReady(cyc, ev);
        checkOutput("held busy cycles", 16'(cyc), 16'd8);
        checkOutput("held early valid", 16'(ev), 16'd0);
        checkOutput("held mult lo", 16'(o_result), 16'd6);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        checkOutput("held addu result", 16'(o_result), 16'd2);
        checkOutput("held addu valid", 16'(o_valid), 16'd1);
        runSingle("mflo held", OP_MFLO, 8'h00, 8'h00, 8'h06);

        // Reset in the middle of a divide aborts it.
        applyStimulus(OP_DIV, 8'd100, 8'd7);
        repeat (4) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        checkOutput("abort ready", 16'(o_ready), 16'd1);
        checkOutput("abort valid", 16'(o_valid), 16'd0);
        checkOutput("abort result", 16'(o_result), 16'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge i_clk);
            #1;
            if (o_valid) pulses++;
        end
        checkOutput("abort pulses", 16'(pulses), 16'd0);
        runSingle("mflo abort", OP_MFLO, 8'h00, 8'h00, 8'h00);
        runSingle("mfhi abort", OP_MFHI, 8'h00, 8'h00, 8'h00);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SIZEDATA, default 8, datapath width W; legal values are even and at least 4.
REQ-002 SIZEOP, default 6, opcode width.
REQ-003 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  operation request; an operation is accepted on a rising edge where i_valid and o_ready are both 1.
REQ-006 i_opcode  input  SIZEOP  operation code, sampled at acceptance.
REQ-007 i_datoa, i_datob  input  W each  operands, sampled at acceptance.
REQ-008 o_ready  output  1  high only in state IDLE.
REQ-009 o_valid  output  1  one-cycle pulse marking a new o_result.
REQ-010 o_result  output  W  registered result; holds its value between o_valid pulses.
REQ-011 o_zero  output  1  registered; equals (o_result == 0).

Function
REQ-012 Single-cycle opcodes shall be: SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, ADDU 100001, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, SLTI 001010, MFHI 010000, MFLO 010010.
REQ-013 Shifts: a shifted by b[$clog2(W)-1:0]; SRA/SRAV sign-fill; the V and non-V forms are identical.
REQ-014 Add/sub: modulo 2^W, no overflow flag. SLT/SLTI: signed compare, result 1 or 0. LUI: b << (W/2).
REQ-015 MFHI/MFLO: result is the HI/LO register.
REQ-016 Unknown opcode: result 0; o_valid still pulses.
REQ-017 Single-cycle latency: accepted at edge k -> o_result/o_valid present in the cycle after edge k; o_ready stays 1, so back-to-back acceptance is allowed every cycle.
REQ-018 Multi-cycle opcodes shall be: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
REQ-019 FSM states are IDLE, MUL and DIV. IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; MUL/DIV->IDLE after exactly W iteration edges (counter 0..W-1). No other transitions are permitted.
REQ-020 Multiply: iterative shift-add, one bit per cycle, 2W-bit product; HI = upper W bits, LO = lower W bits; MULT is signed, MULTU unsigned.
REQ-021 Divide: restoring, one quotient bit per cycle. LO = quotient, HI = remainder. Signed quotient truncates toward zero; signed remainder takes the sign of the dividend.
REQ-022 Divide by zero: LO = all ones, HI = dividend; still W cycles.
REQ-023 Signed DIV of most-negative by -1: LO = dividend, HI = 0.
REQ-024 Multi-cycle timing: accepted at edge k -> o_ready = 0 for cycles k+1..k+W. At edge k+W, HI/LO update, o_result = new LO, o_valid = 1, o_ready = 1.
REQ-025 Operands/opcode changing while busy shall have no effect. i_valid while busy is ignored, not queued.
REQ-026 HI/LO change only on multi-cycle completion.

Reset
REQ-027 Reset assertion takes effect immediately, independent of i_clk: state = IDLE, counter = 0, HI = LO = 0, o_result = 0, o_zero = 1, o_valid = 0, o_ready = 1.
REQ-028 Reset during MUL/DIV shall abort the operation: no o_valid pulse, HI/LO = 0.
REQ-029 The first acceptance is allowed on the first rising edge after deassertion.

Verification (W=8)
REQ-030 ADDU a=100, b=27 -> next cycle o_result=127, o_valid=1, o_zero=0; then SUBU 5-5 -> 0, o_zero=1 on the following cycle.
REQ-031 SRA a=0x80, b=0x0B (amount 3) -> 0xF0; SRL same -> 0x10; LUI b=0x12 -> 0x20; SLT a=0xFF, b=0x01 -> 1.
REQ-032 MULT a=0xFD(-3), b=5 -> o_ready low exactly 8 cycles, o_result=0xF1; then MFHI -> 0xFF, MFLO -> 0xF1; MULTU same operands -> HI=0x04, LO=0xF1.
REQ-033 DIV a=0xF9(-7), b=2 -> LO=0xFD, HI=0xFF. DIVU a=0x2A, b=0 -> LO=0xFF, HI=0x2A. DIV 0x80 by 0xFF -> LO=0x80, HI=0.
REQ-034 i_valid held with ADDU while MULT busy -> no extra o_valid until MULT completes; ADDU accepted only once o_ready=1.
REQ-035 i_rst_n pulsed low at iteration 4 of DIV -> o_ready=1 immediately, no o_valid pulse, MFLO afterwards returns 0.
